// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the 8080-style bus between the CPU and one DMA master with wait-state READY and tenure-limited HOLD/HLDA
module bus_arbiter #(
  parameter logic [15:0] SLOW_BASE = 16'hF000,
  parameter int MEM_WAIT = 0,
  parameter int SLOW_WAIT = 3,
  parameter int IO_WAIT = 2,
  parameter int DMA_MAX = 16
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic [15:0] cpu_add,
  input  logic        cpu_rdn,
  input  logic        cpu_wrn,
  input  logic        cpu_io_mn,
  output logic        cpu_ready,
  input  logic        dma_hold,
  output logic        dma_hlda,
  input  logic [15:0] dma_add,
  input  logic        dma_rdn,
  input  logic        dma_wrn,
  input  logic        dma_io_mn,
  output logic        dma_ready,
  output logic [15:0] mem_add,
  output logic        mem_rdn,
  output logic        mem_wrn,
  output logic        mem_io_mn,
  output logic        bus_owner
);
  localparam int WMAX = (MEM_WAIT > SLOW_WAIT ? (MEM_WAIT > IO_WAIT ? MEM_WAIT : IO_WAIT)
                                              : (SLOW_WAIT > IO_WAIT ? SLOW_WAIT : IO_WAIT));
  localparam int CW = $clog2(WMAX + 1) < 1 ? 1 : $clog2(WMAX + 1);
  localparam int TW = $clog2(DMA_MAX + 1) < 1 ? 1 : $clog2(DMA_MAX + 1);
  typedef enum logic [1:0] {CPU_OWN, DMA_OWN, DMA_DRAIN} state_t;
  state_t state, state_n;
  logic cpu_owed, cpu_owed_n, active_q;
  logic strb_cpu, strb_dma, strb_own, ready_own;
  logic [CW-1:0] cnt, w;
  logic [TW-1:0] ten, ten_n;
  assign bus_owner = state != CPU_OWN;
  assign dma_hlda = state == DMA_OWN;
  assign mem_add = bus_owner ? dma_add : cpu_add;
  assign mem_rdn = bus_owner ? dma_rdn : cpu_rdn;
  assign mem_wrn = bus_owner ? dma_wrn : cpu_wrn;
  assign mem_io_mn = bus_owner ? dma_io_mn : cpu_io_mn;
  assign strb_cpu = !cpu_rdn || !cpu_wrn;
  assign strb_dma = !dma_rdn || !dma_wrn;
  assign strb_own = bus_owner ? strb_dma : strb_cpu;
  // Wait lookup always uses the owner's muxed signals
  assign w = mem_io_mn ? CW'(IO_WAIT) : (mem_add >= SLOW_BASE) ? CW'(SLOW_WAIT) : CW'(MEM_WAIT);
  assign ready_own = !strb_own || (active_q && cnt == '0) || (!active_q && w == '0);
  assign cpu_ready = bus_owner ? !strb_cpu : ready_own;
  assign dma_ready = bus_owner ? ready_own : !strb_dma;
  always_comb begin
    state_n = state;
    ten_n = ten;
    cpu_owed_n = (!bus_owner && active_q && !strb_cpu) ? 1'b0 : cpu_owed;
    case (state)
      CPU_OWN: begin
        if (dma_hold && !cpu_owed && !strb_cpu && !active_q) begin
          state_n = DMA_OWN;
          ten_n = '0;
        end
      end
      DMA_OWN: begin
        ten_n = (ten == TW'(DMA_MAX)) ? ten : ten + 1'b1;
        if (!dma_hold && !strb_dma) state_n = CPU_OWN;
        else if (dma_hold && ten == TW'(DMA_MAX) && strb_cpu) state_n = DMA_DRAIN;
      end
      DMA_DRAIN: begin
        if (!strb_dma) begin
          state_n = CPU_OWN;
          cpu_owed_n = 1'b1;
        end
      end
      default: state_n = CPU_OWN;
    endcase
  end
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state <= CPU_OWN;
      ten <= '0;
      cpu_owed <= 1'b0;
      active_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ten <= ten_n;
      cpu_owed <= cpu_owed_n;
      active_q <= strb_own;
      if (strb_own && !active_q) cnt <= w;
      else if (active_q && cnt != '0) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter with default wait/tenure parameters
module tb_bus_arbiter;
  logic clock = 1'b0, reset_in = 1'b0;
  logic [15:0] cpu_add = '0, dma_add = '0, mem_add;
  logic cpu_rdn = 1'b1, cpu_wrn = 1'b1, cpu_io_mn = 1'b0, cpu_ready;
  logic dma_rdn = 1'b1, dma_wrn = 1'b1, dma_io_mn = 1'b0, dma_ready;
  logic dma_hold = 1'b0, dma_hlda, mem_rdn, mem_wrn, mem_io_mn, bus_owner;
  int total = 0, bad = 0;
  typedef struct {string tag; logic [15:0] val;} exp_t;
  exp_t sb[$];

  bus_arbiter dut (
    .clock(clock), .reset_in(reset_in),
    .cpu_add(cpu_add), .cpu_rdn(cpu_rdn), .cpu_wrn(cpu_wrn), .cpu_io_mn(cpu_io_mn),
    .cpu_ready(cpu_ready), .dma_hold(dma_hold), .dma_hlda(dma_hlda),
    .dma_add(dma_add), .dma_rdn(dma_rdn), .dma_wrn(dma_wrn), .dma_io_mn(dma_io_mn),
    .dma_ready(dma_ready), .mem_add(mem_add), .mem_rdn(mem_rdn), .mem_wrn(mem_wrn),
    .mem_io_mn(mem_io_mn), .bus_owner(bus_owner)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic ck(input string tag, input logic [15:0] exp, input logic [15:0] obs);
    push(tag, exp);
    pop_check(obs);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    push("rst_owner", 16'd0);
    push("rst_hlda", 16'd0);
    push("rst_cpu_ready", 16'd1);
    push("rst_dma_ready", 16'd1);
    pop_check({15'd0, bus_owner});
    pop_check({15'd0, dma_hlda});
    pop_check({15'd0, cpu_ready});
    pop_check({15'd0, dma_ready});
    #10 reset_in = 1'b1;
    tick();
    // zero-wait memory read
    cpu_add = 16'h0100; cpu_rdn = 1'b0; #1;
    ck("mem0_ready_pre", 16'd1, {15'd0, cpu_ready});
    ck("mem0_add", 16'h0100, mem_add);
    tick();
    ck("mem0_ready_post", 16'd1, {15'd0, cpu_ready});
    ck("mem0_rdn", 16'd0, {15'd0, mem_rdn});
    cpu_rdn = 1'b1;
    tick();
    // slow region read: three wait edges
    cpu_add = 16'hF010; cpu_rdn = 1'b0; #1;
    ck("slow_ready_pre", 16'd0, {15'd0, cpu_ready});
    for (int i = 0; i < 3; i++) begin
      tick();
      ck("slow_ready_wait", 16'd0, {15'd0, cpu_ready});
    end
    tick();
    ck("slow_ready_done", 16'd1, {15'd0, cpu_ready});
    cpu_rdn = 1'b1;
    tick();
    // IO write: two wait edges
    cpu_add = 16'h0010; cpu_io_mn = 1'b1; cpu_wrn = 1'b0; #1;
    ck("io_ready_pre", 16'd0, {15'd0, cpu_ready});
    ck("io_mem_io_mn", 16'd1, {15'd0, mem_io_mn});
    for (int i = 0; i < 2; i++) begin
      tick();
      ck("io_ready_wait", 16'd0, {15'd0, cpu_ready});
    end
    tick();
    ck("io_ready_done", 16'd1, {15'd0, cpu_ready});
    cpu_wrn = 1'b1; cpu_io_mn = 1'b0;
    tick();
    // hold during CPU fetch
    cpu_add = 16'h0200; cpu_rdn = 1'b0; dma_hold = 1'b1;
    tick();
    ck("fetch_hlda0", 16'd0, {15'd0, dma_hlda});
    tick();
    ck("fetch_hlda1", 16'd0, {15'd0, dma_hlda});
    cpu_rdn = 1'b1;
    tick();
    ck("fetch_end_hlda", 16'd0, {15'd0, dma_hlda});
    tick();
    ck("grant_hlda", 16'd1, {15'd0, dma_hlda});
    ck("grant_owner", 16'd1, {15'd0, bus_owner});
    dma_add = 16'h0300; dma_rdn = 1'b0; #1;
    ck("dma_mem_add", 16'h0300, mem_add);
    ck("dma_ready", 16'd1, {15'd0, dma_ready});
    dma_hold = 1'b0;
    tick();
    ck("hold_drop_mid_owner", 16'd1, {15'd0, bus_owner});
    dma_rdn = 1'b1;
    tick();
    ck("release_owner", 16'd0, {15'd0, bus_owner});
    ck("release_hlda", 16'd0, {15'd0, dma_hlda});
    // non-owner DMA strobe
    dma_rdn = 1'b0; #1;
    ck("nonown_dma_ready", 16'd0, {15'd0, dma_ready});
    ck("nonown_mem_rdn_hi", 16'd1, {15'd0, mem_rdn});
    cpu_add = 16'h0100; cpu_rdn = 1'b0; #1;
    ck("nonown_mem_rdn_lo", 16'd0, {15'd0, mem_rdn});
    tick();
    ck("nonown_dma_ready2", 16'd0, {15'd0, dma_ready});
    cpu_rdn = 1'b1; dma_rdn = 1'b1;
    tick();
    tick();
    // tenure limit with a pending CPU read
    dma_hold = 1'b1;
    tick();
    ck("ten_grant", 16'd1, {15'd0, dma_hlda});
    dma_add = 16'h0400; dma_rdn = 1'b0;
    cpu_add = 16'h0500; cpu_rdn = 1'b0; #1;
    ck("ten_cpu_stall", 16'd0, {15'd0, cpu_ready});
    for (int i = 0; i < 16; i++) begin
      tick();
      ck("ten_hlda_held", 16'd1, {15'd0, dma_hlda});
      ck("ten_cpu_ready", 16'd0, {15'd0, cpu_ready});
    end
    tick();
    ck("drain_hlda", 16'd0, {15'd0, dma_hlda});
    ck("drain_owner", 16'd1, {15'd0, bus_owner});
    ck("drain_mem_add", 16'h0400, mem_add);
    ck("drain_cpu_ready", 16'd0, {15'd0, cpu_ready});
    dma_rdn = 1'b1;
    tick();
    ck("owed_owner", 16'd0, {15'd0, bus_owner});
    ck("owed_mem_add", 16'h0500, mem_add);
    ck("owed_cpu_ready", 16'd1, {15'd0, cpu_ready});
    tick();
    ck("owed_no_grant", 16'd0, {15'd0, dma_hlda});
    cpu_rdn = 1'b1;
    tick();
    ck("owed_clear_edge", 16'd0, {15'd0, dma_hlda});
    tick();
    ck("regrant_hlda", 16'd1, {15'd0, dma_hlda});
    // async reset mid DMA cycle
    dma_add = 16'h0600; dma_rdn = 1'b0; cpu_add = 16'h0700;
    tick();
    ck("pre_rst_mem_add", 16'h0600, mem_add);
    #2 reset_in = 1'b0;
    #1;
    ck("async_rst_owner", 16'd0, {15'd0, bus_owner});
    ck("async_rst_hlda", 16'd0, {15'd0, dma_hlda});
    ck("async_rst_mem_add", 16'h0700, mem_add);
    dma_hold = 1'b0; dma_rdn = 1'b1;
    #2 reset_in = 1'b1;
    tick();
    cpu_add = 16'hF010; cpu_rdn = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ck("post_rst_wait", 16'd0, {15'd0, cpu_ready});
    end
    tick();
    ck("post_rst_done", 16'd1, {15'd0, cpu_ready});
    cpu_rdn = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
